alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Front-panel controller for the 8-bit ALU: turns two raw push-buttons and the switch bank into
//  one-cycle load strobes (A, B, opcode) for the ALU's operand/opcode registers. It validates the
//  opcode, captures the ALU result and holds it for display. Sits between board I/O and the ALU.
// PARAMETERS
//  DATA_W     8        switch/operand/result width; ALU opcode is the low 6 bits of the switches
//  DB_CYCLES  500000   debounce stable-time in clk cycles (used only with ALU_SEQ_DEBOUNCE_EN)
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  sw           in   DATA_W  raw switch bank (asynchronous)
//  btn_next     in   1       raw "advance" button (asynchronous, active-high)
//  btn_clr      in   1       raw "clear" button (asynchronous, active-high)
//  alu_data     out  DATA_W  operand/opcode bus to the ALU input
//  alu_ld_a     out  1       ALU operand-A load strobe
//  alu_ld_b     out  1       ALU operand-B load strobe
//  alu_ld_op    out  1       ALU opcode load strobe
//  alu_result   in   DATA_W  combinational ALU result
//  res_q        out  DATA_W  captured result
//  res_valid    out  1       res_q holds a fresh result
//  op_err       out  1       last opcode entered was illegal
//  state_o      out  3       current state encoding, for LEDs
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=S_A; alu_data=0, all ld strobes=0, res_q=0, res_valid=0,
//    op_err=0; sync/debounce/edge flops cleared. Deassertion takes effect on the next posedge.
//  - Button conditioning: 2-flop synchroniser, then a rising-edge detector yielding a 1-cycle
//    pulse (nxt_p, clr_p). sw passes through its own 2-flop synchroniser (sw_s).
//    Latency without the macro: button rise -> pulse at the 3rd posedge.
//  - All outputs are registered. At most one ld strobe is high in any cycle, and each lasts 1 cycle.
//  - FSM states: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_CAP=4, S_SHOW=5, S_ERR=6.
//    S_A   + nxt_p : alu_data<=sw_s, alu_ld_a<=1, res_valid<=0 -> S_B
//    S_B   + nxt_p : alu_data<=sw_s, alu_ld_b<=1 -> S_OP
//    S_OP  + nxt_p : if sw_s[5:0] is legal: alu_data<=sw_s, alu_ld_op<=1, op_err<=0 -> S_EXEC
//                    else op_err<=1, no strobe -> S_ERR
//    S_EXEC        : 1 cycle while ALU captures opcode (alu_ld_op high this cycle) -> S_CAP
//    S_CAP         : res_q<=alu_result, res_valid<=1 -> S_SHOW
//    S_SHOW + nxt_p: -> S_A (res_q kept; res_valid cleared on the next A load)
//    S_ERR  + nxt_p: op_err<=0 -> S_OP (operands A/B retained, opcode retry)
//    Without a pulse, every state except S_EXEC/S_CAP holds.
//  - Legal opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA,
//    000010 SRL, 100111 NOR. Upper sw bits (>=6) are ignored for validation.
//  - clr_p has priority over nxt_p in any state. It forces S_A, clears the strobes, res_valid
//    and op_err, and leaves res_q unchanged. In S_EXEC/S_CAP it aborts with no capture.
//  - Simultaneous nxt_p and clr_p: clear wins and nxt_p is dropped.
//  - Button held: one pulse per press. Pulses arriving in S_EXEC/S_CAP are discarded.
//  - Unused state encodings (7) recover to S_A on the next clock.
// CONFIGURATION
//  ALU_SEQ_DEBOUNCE_EN defined: after the synchroniser, a counter requires the level to be stable
//    DB_CYCLES consecutive cycles before the filtered level changes. Edge detection runs on the
//    filtered level. Latency = 2 + DB_CYCLES + 1 cycles.
//  Undefined: no counter; edge detection runs directly on the synchronised level.
// STRUCTURE
//  - Package alu_pkg: opcode localparams (OP_ADD..OP_NOR), state encodings S_A..S_ERR, and the
//    function is_legal_op(logic [5:0]).
//  - Sub-module alu_seq_btn_cond: sync + optional debounce + edge pulse. Instantiated for
//    btn_next and btn_clr.
//  - Top level holds the sw synchroniser, the FSM and the output registers.
// TESTING (macro undefined unless noted; ALU model attached)
//  1. sw=0x05, next; sw=0x03, next; sw=0x20, next -> ld_a/ld_b/ld_op each 1 cycle in order;
//     2 cycles after ld_op, res_q=0x08 and res_valid=1.
//  2. A=0xF0, B=0x02, op=0x03 (SRA) -> res_q=0xFC. With op=0x02 (SRL) -> res_q=0x3C.
//  3. op=0x3F at S_OP -> op_err=1, state=6, no ld_op. Then sw=0x22 + next -> S_OP; next ->
//     SUB result, op_err=0.
//  4. clr asserted in the same cycle as next in S_B, and separately during S_EXEC -> state=0,
//     no strobe, res_valid=0, res_q unchanged.
//  5. rst_n pulsed low mid-S_CAP, asynchronous to clk -> all outputs zero immediately, state=0.
//  6. ALU_SEQ_DEBOUNCE_EN, DB_CYCLES=4: bounce of 3-cycle glitches -> no pulse; a stable press
//     -> exactly one pulse 7 cycles after the rise.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, sequencer state encodings and opcode legality check
package alu_pkg;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_CAP  = 3'd4,
    S_SHOW = 3'd5,
    S_ERR  = 3'd6
  } state_t;
  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
  endfunction
endpackage

// File: rtl/alu_seq_btn_cond.sv
// alu_seq_btn_cond: button synchroniser, optional debounce (ALU_SEQ_DEBOUNCE_EN) and rising-edge pulse
module alu_seq_btn_cond #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  logic s1, s2, f, f_d;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt;
  // filtered level only follows the synchronised level after DB_CYCLES stable cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      f <= 1'b0;
    end else if (s2 == f) cnt <= '0;
    else if (cnt == CW'(DB_CYCLES - 1)) begin
      f <= s2;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
`else
  assign f = s2;
`endif
  // two-flop synchroniser and registered one-cycle rising-edge pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      f_d <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      f_d <= f;
      pulse <= f & ~f_d;
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: front-panel A/B/opcode load sequencer with result capture (ALU_SEQ_DEBOUNCE_EN enables debounce)
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_next,
  input  logic              btn_clr,
  output logic [DATA_W-1:0] alu_data,
  output logic              alu_ld_a,
  output logic              alu_ld_b,
  output logic              alu_ld_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] res_q,
  output logic              res_valid,
  output logic              op_err,
  output logic [2:0]        state_o
);
  logic [DATA_W-1:0] sw1, sw_s;
  logic nxt_p, clr_p;
  state_t state;
  assign state_o = state;
  alu_seq_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_next (.clk(clk), .rst_n(rst_n), .btn(btn_next), .pulse(nxt_p));
  alu_seq_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_clr  (.clk(clk), .rst_n(rst_n), .btn(btn_clr),  .pulse(clr_p));
  // two-flop synchroniser for the switch bank
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sw1 <= '0;
      sw_s <= '0;
    end else begin
      sw1 <= sw;
      sw_s <= sw1;
    end
  // sequencer FSM; strobes default low so each lasts exactly one cycle, clear beats next
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_A;
      alu_data <= '0;
      alu_ld_a <= 1'b0;
      alu_ld_b <= 1'b0;
      alu_ld_op <= 1'b0;
      res_q <= '0;
      res_valid <= 1'b0;
      op_err <= 1'b0;
    end else begin
      alu_ld_a <= 1'b0;
      alu_ld_b <= 1'b0;
      alu_ld_op <= 1'b0;
      if (clr_p) begin
        state <= S_A;
        res_valid <= 1'b0;
        op_err <= 1'b0;
      end else
        case (state)
          S_A: if (nxt_p) begin
            alu_data <= sw_s;
            alu_ld_a <= 1'b1;
            res_valid <= 1'b0;
            state <= S_B;
          end
          S_B: if (nxt_p) begin
            alu_data <= sw_s;
            alu_ld_b <= 1'b1;
            state <= S_OP;
          end
          S_OP: if (nxt_p) begin
            if (is_legal_op(sw_s[5:0])) begin
              alu_data <= sw_s;
              alu_ld_op <= 1'b1;
              op_err <= 1'b0;
              state <= S_EXEC;
            end else begin
              op_err <= 1'b1;
              state <= S_ERR;
            end
          end
          S_EXEC: state <= S_CAP;
          S_CAP: begin
            res_q <= alu_result;
            res_valid <= 1'b1;
            state <= S_SHOW;
          end
          S_SHOW: if (nxt_p) state <= S_A;
          S_ERR: if (nxt_p) begin
            op_err <= 1'b0;
            state <= S_OP;
          end
          default: state <= S_A;
        endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven and scoreboard checks of the ALU front-panel sequencer
module tb_alu_sequencer;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0, rst_n = 1'b0, btn_next = 1'b0, btn_clr = 1'b0;
  logic [7:0] sw = '0, alu_data, alu_result, res_q;
  logic alu_ld_a, alu_ld_b, alu_ld_op, res_valid, op_err;
  logic [2:0] state_o;
  logic [7:0] ra = '0, rb = '0;
  logic [5:0] rop = '0;
  int checks = 0, errors = 0, na = 0, nb = 0, nop = 0, cyc = 0, ldop_cyc = 0;
  logic pv_a = 1'b0, pv_b = 1'b0, pv_op = 1'b0, prv = 1'b0;
  logic [7:0] q[$];
  typedef struct {
    logic [7:0] a, b, op, exp;
    logic err;
  } vec_t;
  vec_t vt[10];

  alu_sequencer #(.DATA_W(8), .DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_next(btn_next), .btn_clr(btn_clr),
    .alu_data(alu_data), .alu_ld_a(alu_ld_a), .alu_ld_b(alu_ld_b), .alu_ld_op(alu_ld_op),
    .alu_result(alu_result), .res_q(res_q), .res_valid(res_valid), .op_err(op_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // external ALU: operand/opcode registers loaded by the strobes, combinational result
  always @(posedge clk) begin
    if (alu_ld_a) ra <= alu_data;
    if (alu_ld_b) rb <= alu_data;
    if (alu_ld_op) rop <= alu_data[5:0];
  end
  always_comb begin
    alu_result = 8'h00;
    case (rop)
      6'h20: alu_result = ra + rb;
      6'h22: alu_result = ra - rb;
      6'h24: alu_result = ra & rb;
      6'h25: alu_result = ra | rb;
      6'h26: alu_result = ra ^ rb;
      6'h27: alu_result = ~(ra | rb);
      6'h03: alu_result = 8'($signed(ra) >>> rb[2:0]);
      6'h02: alu_result = ra >> rb[2:0];
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // strobe monitor and result scoreboard, sampled 1 time unit after each posedge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (alu_ld_a || alu_ld_b || alu_ld_op) begin
      chk("one_strobe", 32'(alu_ld_a) + 32'(alu_ld_b) + 32'(alu_ld_op), 1);
      chk("strobe_1cyc", 32'((alu_ld_a & pv_a) | (alu_ld_b & pv_b) | (alu_ld_op & pv_op)), 0);
    end
    na += 32'(alu_ld_a);
    nb += 32'(alu_ld_b);
    nop += 32'(alu_ld_op);
    if (alu_ld_op) ldop_cyc = cyc;
    if (res_valid && !prv) begin
      if (q.size() == 0) chk("sb_result_expected", q.size(), 1);
      else begin
        chk("res_q", res_q, q.pop_front());
        chk("cap_latency", cyc - ldop_cyc, 2);
      end
    end
    prv = res_valid;
    pv_a = alu_ld_a;
    pv_b = alu_ld_b;
    pv_op = alu_ld_op;
  end

  task automatic press(input bit clr);
    @(negedge clk);
    if (clr) btn_clr = 1'b1; else btn_next = 1'b1;
    repeat (LAT) @(negedge clk);
    btn_next = 1'b0;
    btn_clr = 1'b0;
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n, nb0, nop0;
    logic [7:0] held;
    vt[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};
    vt[1] = '{8'hF0, 8'h02, 8'h03, 8'hFC, 1'b0};
    vt[2] = '{8'hF0, 8'h02, 8'h02, 8'h3C, 1'b0};
    vt[3] = '{8'h09, 8'h04, 8'h22, 8'h05, 1'b0};
    vt[4] = '{8'hCC, 8'hAA, 8'h24, 8'h88, 1'b0};
    vt[5] = '{8'hCC, 8'hAA, 8'h25, 8'hEE, 1'b0};
    vt[6] = '{8'hCC, 8'hAA, 8'h26, 8'h66, 1'b0};
    vt[7] = '{8'hCC, 8'hAA, 8'h27, 8'h11, 1'b0};
    vt[8] = '{8'h10, 8'h20, 8'hE0, 8'h30, 1'b0};
    vt[9] = '{8'h01, 8'h02, 8'h3F, 8'h00, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_alu_data", alu_data, 0);
    chk("rst_strobes", {alu_ld_a, alu_ld_b, alu_ld_op}, 0);
    chk("rst_res", {res_q, res_valid, op_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // latency from button rise to the A strobe
    sw = 8'h5A;
    @(negedge clk);
    btn_next = 1'b1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (alu_ld_a) n = i;
    end
    chk("lat_ld_a", n, LAT + 1);
    chk("ld_a_data", alu_data, 8'h5A);
    @(negedge clk);
    btn_next = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    press(1);
    chk("clr_to_a", state_o, 0);
    // table-driven operand/opcode vectors
    for (int i = 0; i < 10; i++) begin
      n0 = na;
      sw = vt[i].a;
      press(0);
      chk("st_b", state_o, 1);
      chk("ld_a_once", na - n0, 1);
      chk("valid_clr_on_a", res_valid, 0);
      sw = vt[i].b;
      press(0);
      chk("st_op", state_o, 2);
      nop0 = nop;
      sw = vt[i].op;
      if (!vt[i].err) q.push_back(vt[i].exp);
      press(0);
      chk("op_err", op_err, vt[i].err);
      chk("st_after_op", state_o, vt[i].err ? 6 : 5);
      chk("ld_op_cnt", nop - nop0, vt[i].err ? 0 : 1);
      chk("sb_drained", q.size(), 0);
      press(vt[i].err);
      chk("back_to_a", state_o, 0);
      if (!vt[i].err) chk("res_held", res_q, vt[i].exp);
    end
    // long press yields a single pulse
    n0 = na;
    sw = 8'h11;
    @(negedge clk);
    btn_next = 1'b1;
    repeat (25) @(negedge clk);
    btn_next = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("hold_one_pulse_state", state_o, 1);
    chk("hold_one_pulse_cnt", na - n0, 1);
    press(1);
    // illegal opcode, retry with SUB
    sw = 8'h30; press(0);
    sw = 8'h10; press(0);
    nop0 = nop;
    sw = 8'h3F; press(0);
    chk("ill_err", op_err, 1);
    chk("ill_state", state_o, 6);
    chk("ill_no_ld_op", nop - nop0, 0);
    sw = 8'h22; press(0);
    chk("retry_state", state_o, 2);
    chk("retry_err_clr", op_err, 0);
    q.push_back(8'h20);
    press(0);
    chk("retry_state_show", state_o, 5);
    chk("retry_err", op_err, 0);
    chk("retry_drained", q.size(), 0);
    press(0);
    held = res_q;
    // clear and next together in S_B
    sw = 8'h44; press(0);
    nb0 = nb;
    @(negedge clk);
    btn_next = 1'b1;
    btn_clr = 1'b1;
    repeat (LAT) @(negedge clk);
    btn_next = 1'b0;
    btn_clr = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("clrnext_state", state_o, 0);
    chk("clrnext_no_ld_b", nb - nb0, 0);
    chk("clrnext_valid", res_valid, 0);
    chk("clrnext_res", res_q, held);
    // clear landing in S_EXEC aborts the capture
    sw = 8'h07; press(0);
    sw = 8'h08; press(0);
    nop0 = nop;
    sw = 8'h20;
    @(negedge clk);
    btn_next = 1'b1;
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (LAT) @(negedge clk);
    btn_next = 1'b0;
    btn_clr = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("exec_clr_state", state_o, 0);
    chk("exec_clr_ld_op", nop - nop0, 1);
    chk("exec_clr_valid", res_valid, 0);
    chk("exec_clr_res", res_q, held);
    // asynchronous reset in the middle of S_CAP
    sw = 8'h01; press(0);
    sw = 8'h02; press(0);
    sw = 8'h20;
    @(negedge clk);
    btn_next = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #3;
    chk("pre_rst_cap", state_o, 4);
    rst_n = 1'b0;
    #1;
    chk("arst_state", state_o, 0);
    chk("arst_outs", {alu_data, alu_ld_a, alu_ld_b, alu_ld_op, res_q, res_valid, op_err}, 0);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    chk("post_rst_state", state_o, 0);
    chk("post_rst_valid", res_valid, 0);
`ifdef ALU_SEQ_DEBOUNCE_EN
    // short glitches never pass the debounce filter
    sw = 8'h0F; press(0);
    nb0 = nb;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      btn_next = 1'b1;
      repeat (3) @(negedge clk);
      btn_next = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("bounce_state", state_o, 1);
    chk("bounce_no_ld_b", nb - nb0, 0);
    press(1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
